// File: rtl/io_config_loader.sv
// Byte-stream configuration loader for one IO line: assembles words in a shadow
// register and commits them atomically to config_out. Optional CRC-8 trailer: IO_CONFIG_CRC_EN.
module io_config_loader #(
  parameter int CONFIG_WIDTH = 72,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_last,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    done,
  output logic                    error
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_WORDS*WORD_WIDTH-1:0] shadow_flat;
  logic [CONFIG_WIDTH-1:0]         config_q;
  logic                            restart;
  logic                            data_wr;

  // start is ignored only while the commit is in flight
  assign restart = start && (state_q != S_COMMIT);
  assign data_wr = (state_q == S_LOAD) && cfg_valid && !start && (cnt_q <= LAST_DATA);

`ifdef IO_CONFIG_CRC_EN
  localparam logic [CNT_W-1:0] CRC_IDX = CNT_W'(NUM_WORDS);

  logic [7:0] crc_q;
  logic       crc_match;

  function automatic logic [7:0] crc_step(input logic [7:0] crc_in,
                                          input logic [WORD_WIDTH-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign crc_match = (cfg_data[7:0] == crc_q);

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      crc_q <= 8'h00;
    end else if (data_wr) begin
      crc_q <= crc_step(crc_q, cfg_data);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_ready = (state_q == S_LOAD);
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          cnt_d = cnt_q + 1'b1;
`ifdef IO_CONFIG_CRC_EN
          if (cnt_q == CRC_IDX) begin
            state_d = (cfg_last && crc_match) ? S_COMMIT : S_ERROR;
          end else if (cfg_last) begin
            state_d = S_ERROR;
          end
`else
          if (cnt_q == LAST_DATA) begin
            state_d = cfg_last ? S_COMMIT : S_ERROR;
          end else if (cfg_last) begin
            state_d = S_ERROR;
          end
`endif
        end
      end
      S_COMMIT: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      config_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_COMMIT) begin
        config_q <= shadow_flat[CONFIG_WIDTH-1:0];
      end
    end
  end

  // one register per word slot; bits beyond CONFIG_WIDTH are dropped at commit
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
    logic [WORD_WIDTH-1:0] slot_q;
    always_ff @(posedge clock) begin
      if (reset || restart) begin
        slot_q <= '0;
      end else if (data_wr && (cnt_q == CNT_W'(gi))) begin
        slot_q <= cfg_data;
      end
    end
    assign shadow_flat[gi*WORD_WIDTH +: WORD_WIDTH] = slot_q;
  end

  assign config_out = config_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_io_config_loader.sv
// Directed bench for io_config_loader with an expected-outcome scoreboard.
module tb_io_config_loader;

  localparam int CW = 72;
  localparam int NW = 9;
`ifdef IO_CONFIG_CRC_EN
  localparam int TOTAL = NW + 1;
`else
  localparam int TOTAL = NW;
`endif

  logic          clock = 1'b0;
  logic          reset, start, cfg_valid, cfg_last;
  logic [7:0]    cfg_data;
  logic          cfg_ready, done, error;
  logic [CW-1:0] config_out;

  typedef struct {
    logic [CW-1:0] cfg;
    logic          done;
    logic          error;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  io_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .config_out (config_out),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [CW-1:0] d);
    logic [7:0] c = 8'h00;
    for (int b = 0; b < NW; b++) begin
      c = c ^ d[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one word and returns one step after the edge on which it was accepted.
  task automatic send_word(input logic [7:0] d, input logic last);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    forever begin
      @(negedge clock);
      if (cfg_ready || n >= 20) break;
      n++;
    end
    if (n >= 20) check("ready_timeout", 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // last_pos: stream index carrying cfg_last (-1 = none); gap_after: index followed by 3 idle cycles.
  task automatic send_load(input logic [CW-1:0] d, input int last_pos, input int gap_after,
                           input logic crc_flip);
    logic [7:0] w;
    for (int i = 0; i < TOTAL; i++) begin
      w = (i < NW) ? d[i*8 +: 8] : (ref_crc(d) ^ {7'b0, crc_flip});
      send_word(w, i == last_pos);
      if (i == last_pos) break;
      if (i == gap_after) repeat (3) tick();
    end
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   lat = 0;
    while (!(done || error) && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_seen"}, done || error, 1'b1);
    check({tag, "_sb"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_cfg"}, config_out, e.cfg);
      check({tag, "_done"}, done, e.done);
      check({tag, "_error"}, error, e.error);
      check({tag, "_lat"}, lat, e.lat);
    end
    $display("txn %s: config_out=%h done=%0b error=%0b latency=%0d", tag, config_out, done, error, lat);
  endtask

  initial begin : stim
    logic [CW-1:0] d_seq, d_ff, d_rnd, d_rnd2;
    d_seq     = 72'h090807060504030201;
    d_ff      = {CW{1'b1}};
    d_rnd     = {$urandom, $urandom, $urandom};
    d_rnd2    = {$urandom, $urandom, $urandom};
    reset     = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = 8'h00;
    repeat (3) tick();
    check("rst_cfg", config_out, '0);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b0;
    tick();
    check("idle_ready", cfg_ready, 1'b0);

    // basic back-to-back load
    pulse_start();
    check("load_ready", cfg_ready, 1'b1);
    sb.push_back('{d_seq, 1'b1, 1'b0, 1});
    send_load(d_seq, TOTAL - 1, -1, 1'b0);
    wait_result("t1_basic");
    check("t1_ready_low", cfg_ready, 1'b0);

    // upstream stalls 3 cycles between words 4 and 5
    pulse_start();
    sb.push_back('{d_seq, 1'b1, 1'b0, 1});
    send_load(d_seq, TOTAL - 1, 3, 1'b0);
    wait_result("t2_gap");

    // cfg_last on word 3
    pulse_start();
    sb.push_back('{d_seq, 1'b0, 1'b1, 0});
    send_load(d_rnd, 2, -1, 1'b0);
    wait_result("t3_early_last");

    // final word without cfg_last, then a clean 0xFF load
    pulse_start();
    sb.push_back('{d_seq, 1'b0, 1'b1, 0});
    send_load(d_rnd, -1, -1, 1'b0);
    wait_result("t4_no_last");
    pulse_start();
    sb.push_back('{d_ff, 1'b1, 1'b0, 1});
    send_load(d_ff, TOTAL - 1, -1, 1'b0);
    wait_result("t4_all_ff");

    // restart after 5 words, colliding with a transfer that must be dropped
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(d_seq[i*8 +: 8], 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hAA;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_valid = 1'b0;
    sb.push_back('{d_rnd, 1'b1, 1'b0, 1});
    send_load(d_rnd, TOTAL - 1, -1, 1'b0);
    wait_result("t5_restart");

    // start during COMMIT is ignored; one cycle already consumed, so latency 0 here
    pulse_start();
    send_load(d_rnd2, TOTAL - 1, -1, 1'b0);
    sb.push_back('{d_rnd2, 1'b1, 1'b0, 0});
    pulse_start();
    wait_result("t6_start_in_commit");
    tick();
    check("t6_stay_done", done, 1'b1);
    check("t6_ready_low", cfg_ready, 1'b0);

    // reset while in COMMIT
    pulse_start();
    send_load(d_seq, TOTAL - 1, -1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_rst_cfg", config_out, '0);
    check("t7_rst_done", done, 1'b0);
    check("t7_rst_error", error, 1'b0);
    check("t7_rst_ready", cfg_ready, 1'b0);
    $display("txn t7_reset_in_commit: config_out=%h done=%0b error=%0b", config_out, done, error);

`ifdef IO_CONFIG_CRC_EN
    pulse_start();
    sb.push_back('{d_seq, 1'b1, 1'b0, 1});
    send_load(d_seq, TOTAL - 1, -1, 1'b0);
    wait_result("t8_crc_ok");
    pulse_start();
    sb.push_back('{d_seq, 1'b0, 1'b1, 0});
    send_load(d_seq, TOTAL - 1, -1, 1'b1);
    wait_result("t8_crc_bad_same");
    pulse_start();
    sb.push_back('{d_seq, 1'b0, 1'b1, 0});
    send_load(d_rnd, TOTAL - 1, -1, 1'b1);
    wait_result("t8_crc_bad_rnd");
`endif

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
